// File: rtl/i2c_minion_regs_if.sv
// i2c_minion_regs_if: I2C pad-side bus between a bus master (or its pads) and the minion.
//   scl     : serial clock driven by the master
//   sda_in  : wired-AND SDA level seen at the pad
//   sda_out : open-drain data value from the minion (always 0)
//   sda_oe  : minion pull-down enable (1 = pull SDA low)
interface i2c_minion_regs_if;
   logic scl;
   logic sda_in;
   logic sda_out;
   logic sda_oe;
   modport master (output scl, sda_in, input sda_out, sda_oe);
   modport slave (input scl, sda_in, output sda_out, sda_oe);
endinterface

// File: rtl/i2c_minion_regs.sv
// i2c_minion_regs: oversampled I2C target with a pointer-addressed register bank.
//   clk       : system clock, at least 8x SCL (10x with the glitch filter)
//   rst       : synchronous active-high reset
//   bus       : i2c_minion_regs_if.slave (scl, sda_in in; sda_out, sda_oe out)
//   rd_regs   : read-back sources, register i at [i*DATA_W +: DATA_W]
//   wr_regs   : register bank written by the master, same packing
//   wr_strobe : one-cycle pulse when a data byte is committed
//   wr_index  : index of the committed register, valid with wr_strobe
//   busy      : high from address-match ACK until STOP or a non-matching address
// Optional: define I2C_GLITCH_FILTER_EN for a 3-sample majority filter on SCL/SDA.
module i2c_minion_regs #(
   parameter logic [6:0] MINION_ADDR = 7'h12,
   parameter int NREGS = 4,
   parameter int DATA_W = 8,
   localparam int PTR_W = $clog2(NREGS)
) (
   input  logic                    clk,
   input  logic                    rst,
   i2c_minion_regs_if.slave        bus,
   input  logic [NREGS*DATA_W-1:0] rd_regs,
   output logic [NREGS*DATA_W-1:0] wr_regs,
   output logic                    wr_strobe,
   output logic [PTR_W-1:0]        wr_index,
   output logic                    busy
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;
   state_t state_q, state_d;
   logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic scl_f, sda_f, scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic scl_rise, scl_fall, start, stop, addr_match;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shreg_q, shreg_d, rd_cur, rd_nxt;
   logic oe_q, oe_d, ack_q, ack_d, strobe_q, strobe_d, busy_q, busy_d;
   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, idx_q, idx_d;
   logic [NREGS*DATA_W-1:0] wr_regs_q, wr_regs_d;

   always_comb begin
      scl_sync_d = {scl_sync_q[0], bus.scl};
      sda_sync_d = {sda_sync_q[0], bus.sda_in};
      scl_prev_d = scl_f;
      sda_prev_d = sda_f;
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
   logic scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;
   always_comb begin
      scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
      scl_flt_d = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[1]);
      sda_flt_d = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[1]);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
         scl_flt_q <= 1'b1;
         sda_flt_q <= 1'b1;
      end else begin
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
         scl_flt_q <= scl_flt_d;
         sda_flt_q <= sda_flt_d;
      end
   end
   assign scl_f = scl_flt_q;
   assign sda_f = sda_flt_q;
`else
   assign scl_f = scl_sync_q[1];
   assign sda_f = sda_sync_q[1];
`endif

   assign scl_rise = scl_f & ~scl_prev_q;
   assign scl_fall = ~scl_f & scl_prev_q;
   // SDA may only move while SCL has been high for two samples to count as START/STOP
   assign start = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
   assign stop = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
   assign addr_match = shreg_q[7:1] == MINION_ADDR;
   assign ptr_inc = (ptr_q == PTR_W'(NREGS - 1)) ? '0 : ptr_q + PTR_W'(1);
   assign rd_cur = 8'(rd_regs[ptr_q*DATA_W +: DATA_W]);
   assign rd_nxt = 8'(rd_regs[ptr_inc*DATA_W +: DATA_W]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         cnt_q <= '0;
         shreg_q <= '0;
         oe_q <= 1'b0;
         ack_q <= 1'b1;
         strobe_q <= 1'b0;
         busy_q <= 1'b0;
         ptr_q <= '0;
         idx_q <= '0;
         wr_regs_q <= '0;
      end else begin
         state_q <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
         cnt_q <= cnt_d;
         shreg_q <= shreg_d;
         oe_q <= oe_d;
         ack_q <= ack_d;
         strobe_q <= strobe_d;
         busy_q <= busy_d;
         ptr_q <= ptr_d;
         idx_q <= idx_d;
         wr_regs_q <= wr_regs_d;
      end
   end

   // Byte and ACK phases both end on an SCL fall so SDA only moves while SCL is low
   always_comb begin
      state_d = state_q;
      if (start) state_d = ADDR;
      else if (stop) state_d = IDLE;
      else if (scl_fall) begin
         case (state_q)
            ADDR:      if (cnt_q == 4'd8) state_d = addr_match ? ADDR_ACK : IDLE;
            ADDR_ACK:  state_d = shreg_q[0] ? RDATA : PTR;
            PTR:       if (cnt_q == 4'd8) state_d = PTR_ACK;
            PTR_ACK:   state_d = WDATA;
            WDATA:     if (cnt_q == 4'd8) state_d = WDATA_ACK;
            WDATA_ACK: state_d = WDATA;
            RDATA:     if (cnt_q == 4'd8) state_d = RDATA_ACK;
            RDATA_ACK: state_d = ack_q ? IDLE : RDATA;
            default:   state_d = state_q;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      shreg_d = shreg_q;
      oe_d = oe_q;
      ack_d = ack_q;
      strobe_d = 1'b0;
      busy_d = busy_q;
      ptr_d = ptr_q;
      idx_d = idx_q;
      wr_regs_d = wr_regs_q;
      if (start) begin
         cnt_d = '0;
         oe_d = 1'b0;
      end else if (stop) begin
         oe_d = 1'b0;
         busy_d = 1'b0;
      end else if (scl_rise) begin
         if (state_q inside {ADDR, PTR, WDATA}) begin
            shreg_d = {shreg_q[6:0], sda_f};
            cnt_d = cnt_q + 4'd1;
         end
         if (state_q == RDATA) cnt_d = cnt_q + 4'd1;
         if (state_q == RDATA_ACK) ack_d = sda_f;
         // Commit happens on the ACK-bit rise, so an interrupted byte never reaches here
         if (state_q == WDATA_ACK) begin
            wr_regs_d[ptr_q*DATA_W +: DATA_W] = shreg_q[DATA_W-1:0];
            strobe_d = 1'b1;
            idx_d = ptr_q;
            ptr_d = ptr_inc;
         end
      end else if (scl_fall) begin
         case (state_q)
            ADDR: if (cnt_q == 4'd8) begin
               oe_d = addr_match;
               busy_d = addr_match;
               cnt_d = '0;
            end
            ADDR_ACK: begin
               shreg_d = shreg_q[0] ? rd_cur : shreg_q;
               oe_d = shreg_q[0] & ~rd_cur[7];
               cnt_d = '0;
            end
            PTR: if (cnt_q == 4'd8) begin
               oe_d = 1'b1;
               ptr_d = PTR_W'(shreg_q % NREGS);
               cnt_d = '0;
            end
            WDATA: if (cnt_q == 4'd8) begin
               oe_d = 1'b1;
               cnt_d = '0;
            end
            PTR_ACK, WDATA_ACK: begin
               oe_d = 1'b0;
               cnt_d = '0;
            end
            RDATA: begin
               shreg_d = (cnt_q == 4'd8) ? shreg_q : {shreg_q[6:0], 1'b0};
               oe_d = (cnt_q == 4'd8) ? 1'b0 : ~shreg_q[6];
               cnt_d = (cnt_q == 4'd8) ? '0 : cnt_q;
            end
            RDATA_ACK: begin
               ptr_d = ack_q ? ptr_q : ptr_inc;
               shreg_d = ack_q ? shreg_q : rd_nxt;
               oe_d = ~ack_q & ~rd_nxt[7];
            end
            default: oe_d = 1'b0;
         endcase
      end
   end

   assign bus.sda_out = 1'b0;
   assign bus.sda_oe = oe_q;
   assign wr_regs = wr_regs_q;
   assign wr_strobe = strobe_q;
   assign wr_index = idx_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_i2c_minion_regs.sv
// tb_i2c_minion_regs: directed open-drain bus master driving i2c_minion_regs.
module tb_i2c_minion_regs;
   localparam int Q = 5;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   logic [31:0] rd_regs = {8'h44, 8'h33, 8'h22, 8'h11};
   logic [31:0] wr_regs;
   logic wr_strobe, busy;
   logic [1:0] wr_index;
   int checks = 0;
   int errors = 0;
   int strobe_cnt = 0;
   int last_idx = -1;
   logic [7:0] model [4];

   i2c_minion_regs_if bus ();
   assign bus.scl = scl_m;
   assign bus.sda_in = sda_m & ~bus.sda_oe;

   i2c_minion_regs #(.MINION_ADDR(7'h12), .NREGS(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .rd_regs(rd_regs),
      .wr_regs(wr_regs), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_strobe) begin
      strobe_cnt++;
      last_idx = int'(wr_index);
   end

   typedef struct {
      logic [7:0] addr;
      logic [7:0] ptr;
      logic [7:0] data;
      logic [2:0] acks;
      logic       wr;
      int         idx;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] model_packed();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   task automatic bit_xfer(input logic b, output logic r);
      sda_m = b;
      wq(Q);
      scl_m = 1'b1;
      wq(Q);
      r = bus.sda_in;
      wq(Q);
      scl_m = 1'b0;
      wq(Q);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wq(Q);
      scl_m = 1'b1;
      wq(Q);
      sda_m = 1'b0;
      wq(Q);
      scl_m = 1'b0;
      wq(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wq(Q);
      scl_m = 1'b1;
      wq(Q);
      sda_m = 1'b1;
      wq(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
      bit_xfer(1'b1, ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic r;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         bit_xfer(1'b1, r);
         d = {d[6:0], r};
      end
      bit_xfer(nack, r);
   endtask

   initial begin
      logic [2:0] a;
      logic ack, r;
      logic [7:0] d;
      int s0;
      vecs[0] = '{8'h24, 8'h02, 8'hA5, 3'b000, 1'b1, 2};
      vecs[1] = '{8'h24, 8'h00, 8'h5A, 3'b000, 1'b1, 0};
      vecs[2] = '{8'h24, 8'h05, 8'hFF, 3'b000, 1'b1, 1};
      vecs[3] = '{8'h24, 8'hFF, 8'h81, 3'b000, 1'b1, 3};
      vecs[4] = '{8'h26, 8'h01, 8'h77, 3'b111, 1'b0, 0};
      vecs[5] = '{8'h24, 8'h02, 8'h3C, 3'b000, 1'b1, 2};
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
      wq(4);
      rst = 1'b0;
      wq(2);
      chk("rst_sda_oe", bus.sda_oe, 0);
      chk("rst_sda_out", bus.sda_out, 0);
      chk("rst_wr_regs", wr_regs, 0);
      chk("rst_wr_strobe", wr_strobe, 0);
      chk("rst_wr_index", wr_index, 0);
      chk("rst_busy", busy, 0);

      for (int v = 0; v < 6; v++) begin
         s0 = strobe_cnt;
         i2c_start();
         write_byte(vecs[v].addr, a[2]);
         write_byte(vecs[v].ptr, a[1]);
         chk($sformatf("v%0d_busy", v), busy, vecs[v].wr);
         write_byte(vecs[v].data, a[0]);
         chk($sformatf("v%0d_acks", v), a, vecs[v].acks);
         if (vecs[v].wr) model[vecs[v].idx] = vecs[v].data;
         i2c_stop();
         chk($sformatf("v%0d_strobes", v), strobe_cnt - s0, vecs[v].wr ? 1 : 0);
         if (vecs[v].wr) chk($sformatf("v%0d_index", v), last_idx, vecs[v].idx);
         chk($sformatf("v%0d_wr_regs", v), wr_regs, model_packed());
         chk($sformatf("v%0d_busy_stop", v), busy, 0);
      end

      // pointer wrap on writes
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h24, a[2]);
      write_byte(8'h03, a[1]);
      write_byte(8'h11, a[0]);
      write_byte(8'h22, ack);
      i2c_stop();
      model[3] = 8'h11;
      model[0] = 8'h22;
      chk("wrap_acks", {a, ack}, 0);
      chk("wrap_strobes", strobe_cnt - s0, 2);
      chk("wrap_last_index", last_idx, 0);
      chk("wrap_wr_regs", wr_regs, model_packed());

      // set pointer, repeated START, burst read with wrap-free increment
      i2c_start();
      write_byte(8'h24, a[2]);
      write_byte(8'h01, a[1]);
      i2c_start();
      write_byte(8'h25, a[0]);
      chk("rd_acks", a, 0);
      read_byte(1'b0, d);
      chk("rd_byte0", d, 8'h22);
      read_byte(1'b0, d);
      chk("rd_byte1", d, 8'h33);
      read_byte(1'b1, d);
      chk("rd_byte2", d, 8'h44);
      chk("rd_release", bus.sda_oe, 0);
      write_byte(8'h24, ack);
      chk("rd_idle_no_ack", ack, 1);
      i2c_stop();

      // non-matching address is ignored
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h30, a[2]);
      chk("nomatch_busy", busy, 0);
      write_byte(8'h00, a[1]);
      write_byte(8'h77, a[0]);
      i2c_stop();
      chk("nomatch_acks", a, 3'b111);
      chk("nomatch_strobes", strobe_cnt - s0, 0);
      chk("nomatch_wr_regs", wr_regs, model_packed());

      // STOP after 4 data bits discards the partial byte
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h24, a[2]);
      write_byte(8'h00, a[1]);
      for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
      i2c_stop();
      chk("partial_strobes", strobe_cnt - s0, 0);
      chk("partial_wr_regs", wr_regs, model_packed());
      write_byte(8'h24, ack);
      chk("partial_idle_no_ack", ack, 1);

      // reset in the middle of a read byte (rd_regs[2]=0x33, MSB 0 -> SDA pulled)
      i2c_start();
      write_byte(8'h24, a[2]);
      write_byte(8'h02, a[1]);
      i2c_start();
      write_byte(8'h25, a[0]);
      sda_m = 1'b1;
      wq(Q);
      scl_m = 1'b1;
      wq(Q);
      chk("rdrst_oe_before", bus.sda_oe, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rdrst_oe_after", bus.sda_oe, 0);
      chk("rdrst_wr_regs", wr_regs, 0);
      chk("rdrst_busy", busy, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
      wq(4 * Q);
      i2c_start();
      write_byte(8'h25, ack);
      read_byte(1'b1, d);
      i2c_stop();
      chk("rdrst_ptr0_read", d, 8'h11);

`ifdef I2C_GLITCH_FILTER_EN
      // a 1-clk SCL pulse mid-byte must not shift an extra bit
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h24, a[2]);
      write_byte(8'h01, a[1]);
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(i[0] ? 1'b1 : 1'b0, r);
         if (i == 4) begin
            scl_m = 1'b1;
            wq(1);
            scl_m = 1'b0;
            wq(Q);
         end
      end
      bit_xfer(1'b1, a[0]);
      i2c_stop();
      model[1] = 8'hAA;
      chk("glitch_acks", a, 0);
      chk("glitch_strobes", strobe_cnt - s0, 1);
      chk("glitch_wr_regs", wr_regs, model_packed());
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
